// File: rtl/tx_pkg.sv
// Shared definitions for the transmit stream serializer: FSM state encoding
// and default widths.
package tx_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } tx_state_e;

  localparam int TX_DATA_WIDTH = 32;
  localparam int TX_CPB_WIDTH  = 32;

endpackage

// File: rtl/tx_bit_timer.sv
// Bit-period timer: counts cycles_per_bit clocks per serial bit and flags the
// first and last cycle of each bit. The period is latched when a word loads.
module tx_bit_timer #(
  parameter int CPB_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 run,
  input  logic [CPB_WIDTH-1:0] cycles_per_bit,
  output logic                 bit_stb,
  output logic                 bit_end
);

  localparam logic [CPB_WIDTH-1:0] CPB_ZERO = {CPB_WIDTH{1'b0}};
  localparam logic [CPB_WIDTH-1:0] CPB_ONE  = CPB_WIDTH'(1);

  logic [CPB_WIDTH-1:0] cnt_r;
  logic [CPB_WIDTH-1:0] cpb_r;
  logic [CPB_WIDTH-1:0] cpb_eff_s;

  // A zero period is promoted to one cycle per bit
  always_comb begin
    cpb_eff_s = cycles_per_bit;
    if (cycles_per_bit == CPB_ZERO) begin
      cpb_eff_s = CPB_ONE;
    end else begin
      cpb_eff_s = cycles_per_bit;
    end
  end

  assign bit_stb = run && (cnt_r == CPB_ZERO);
  assign bit_end = run && (cnt_r == (cpb_r - CPB_ONE));

  // Cycle counter and latched bit period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= CPB_ZERO;
      cpb_r <= CPB_ONE;
    end else if (load) begin
      cnt_r <= CPB_ZERO;
      cpb_r <= cpb_eff_s;
    end else if (run) begin
      cnt_r <= bit_end ? CPB_ZERO : (cnt_r + CPB_ONE);
    end else begin
      cnt_r <= CPB_ZERO;
    end
  end

endmodule

// File: rtl/tx_stream_serializer.sv
// Word-to-bitstream serializer with a one-word holding register feeding a
// shift register, so consecutive words and frames stream without gaps.
module tx_stream_serializer
  import tx_pkg::*;
#(
  parameter int DATA_WIDTH = TX_DATA_WIDTH,
  parameter int CPB_WIDTH  = TX_CPB_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  input  logic                  last_i,
  output logic                  ready_o,
  input  logic [CPB_WIDTH-1:0]  cycles_per_bit,
  input  logic                  msb_first_i,
  output logic                  data_o,
  output logic                  valid_o,
  output logic                  bit_stb_o,
  output logic                  frame_end_o,
  output logic                  underrun_o
);

  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [BW-1:0] BIT_ZERO = {BW{1'b0}};
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  tx_state_e             state_r;
  tx_state_e             state_nxt_s;
  logic [DATA_WIDTH-1:0] hold_data_r;
  logic                  hold_last_r;
  logic                  hold_full_r;
  logic                  hold_full_nxt_s;
  logic                  ready_r;
  logic [DATA_WIDTH-1:0] shift_data_r;
  logic                  shift_last_r;
  logic                  msb_r;
  logic [BW-1:0]         bit_cnt_r;
  logic                  underrun_r;
  logic                  accept_s;
  logic                  load_s;
  logic                  word_end_s;
  logic                  shifting_s;
  logic                  bit_stb_s;
  logic                  bit_end_s;

  assign shifting_s = (state_r == ST_SHIFT);
  assign accept_s   = valid_i && ready_r;
  assign word_end_s = shifting_s && bit_end_s && (bit_cnt_r == BIT_LAST);
  // Transfer requires a full hold, while accept requires an empty one
  assign load_s     = hold_full_r && ((state_r == ST_IDLE) || word_end_s);

  tx_bit_timer #(
    .CPB_WIDTH (CPB_WIDTH)
  ) u_bit_timer (
    .clk            (clk_i),
    .rst_n          (rst_ni),
    .load           (load_s),
    .run            (shifting_s),
    .cycles_per_bit (cycles_per_bit),
    .bit_stb        (bit_stb_s),
    .bit_end        (bit_end_s)
  );

  // Next FSM state
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (hold_full_r) begin
          state_nxt_s = ST_SHIFT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (word_end_s && !hold_full_r) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Hold occupancy after this edge
  always_comb begin
    hold_full_nxt_s = hold_full_r;
    if (accept_s) begin
      hold_full_nxt_s = 1'b1;
    end else if (load_s) begin
      hold_full_nxt_s = 1'b0;
    end else begin
      hold_full_nxt_s = hold_full_r;
    end
  end

  // FSM state, holding register and ready flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= ST_IDLE;
      hold_data_r <= {DATA_WIDTH{1'b0}};
      hold_last_r <= 1'b0;
      hold_full_r <= 1'b0;
      ready_r     <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      hold_full_r <= hold_full_nxt_s;
      ready_r     <= !hold_full_nxt_s;
      if (accept_s) begin
        hold_data_r <= data_i;
        hold_last_r <= last_i;
      end else begin
        hold_data_r <= hold_data_r;
        hold_last_r <= hold_last_r;
      end
    end
  end

  // Shift register, bit counter and underrun pulse
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_data_r <= {DATA_WIDTH{1'b0}};
      shift_last_r <= 1'b0;
      msb_r        <= 1'b0;
      bit_cnt_r    <= BIT_ZERO;
      underrun_r   <= 1'b0;
    end else begin
      underrun_r <= word_end_s && !hold_full_r && !shift_last_r;
      if (load_s) begin
        shift_data_r <= hold_data_r;
        shift_last_r <= hold_last_r;
        msb_r        <= msb_first_i;
        bit_cnt_r    <= BIT_ZERO;
      end else if (word_end_s) begin
        shift_last_r <= 1'b0;
        bit_cnt_r    <= BIT_ZERO;
      end else if (shifting_s && bit_end_s) begin
        shift_data_r <= msb_r ? {shift_data_r[DATA_WIDTH-2:0], 1'b0}
                              : {1'b0, shift_data_r[DATA_WIDTH-1:1]};
        bit_cnt_r    <= bit_cnt_r + BIT_ONE;
      end else begin
        shift_data_r <= shift_data_r;
        bit_cnt_r    <= bit_cnt_r;
      end
    end
  end

  assign ready_o     = ready_r;
  assign valid_o     = shifting_s;
  assign data_o      = shifting_s && (msb_r ? shift_data_r[DATA_WIDTH-1] : shift_data_r[0]);
  assign bit_stb_o   = bit_stb_s;
  assign frame_end_o = shifting_s && shift_last_r && (bit_cnt_r == BIT_LAST);
  assign underrun_o  = underrun_r;

endmodule

// File: tb/tb_tx_stream_serializer.sv
// Directed bench for tx_stream_serializer with DATA_WIDTH=8: one task per
// scenario, expected streams built from hand-chosen words.
module tb_tx_stream_serializer;

  localparam int DW = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic          valid_i = 1'b0;
  logic          last_i = 1'b0;
  logic          ready_o;
  logic [CW-1:0] cpb = 8'd1;
  logic          msb = 1'b1;
  logic          data_o;
  logic          valid_o;
  logic          bit_stb_o;
  logic          frame_end_o;
  logic          underrun_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic cap_v [0:63];
  logic cap_d [0:63];
  logic cap_s [0:63];
  logic cap_f [0:63];
  logic cap_u [0:63];

  tx_stream_serializer #(.DATA_WIDTH(DW), .CPB_WIDTH(CW)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .data_i         (data_i),
    .valid_i        (valid_i),
    .last_i         (last_i),
    .ready_o        (ready_o),
    .cycles_per_bit (cpb),
    .msb_first_i    (msb),
    .data_o         (data_o),
    .valid_o        (valid_o),
    .bit_stb_o      (bit_stb_o),
    .frame_end_o    (frame_end_o),
    .underrun_o     (underrun_o)
  );

  always #5 clk = ~clk;

  // Record outputs #1 after each of n edges; drops valid_i once accepted.
  task automatic capture(input int base, input int n);
    logic fire;
    for (int i = 0; i < n; i++) begin
      fire = valid_i && ready_o;
      @(posedge clk); #1;
      if (fire) begin
        valid_i = 1'b0;
        last_i  = 1'b0;
      end
      cap_v[base+i] = valid_o;
      cap_d[base+i] = data_o;
      cap_s[base+i] = bit_stb_o;
      cap_f[base+i] = frame_end_o;
      cap_u[base+i] = underrun_o;
    end
  endtask

  // Waits (bounded) for ready, presents one word and returns #1 after the accepting edge.
  task automatic send_word(input logic [DW-1:0] w, input logic l);
    int waited;
    waited = 0;
    while (ready_o !== 1'b1 && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    total_cnt++;
    if (ready_o !== 1'b1) $display("FAIL ready_wait: ready_o=%b required 1", ready_o);
    else pass_cnt++;
    data_i  = w;
    last_i  = l;
    valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    last_i  = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    #12;
    total_cnt++;
    if ({ready_o, data_o, valid_o, bit_stb_o, frame_end_o, underrun_o} !== 6'b000000)
      $display("FAIL reset_outputs: got %b required 000000",
               {ready_o, data_o, valid_o, bit_stb_o, frame_end_o, underrun_o});
    else pass_cnt++;
    @(posedge clk); #1;
    rst_ni = 1'b1;
    #1;
    total_cnt++;
    if (ready_o !== 1'b0) $display("FAIL ready_before_edge: got %b required 0", ready_o);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (ready_o !== 1'b1) $display("FAIL ready_after_release: got %b required 1", ready_o);
    else pass_cnt++;
  endtask

  task automatic test_msb_single(input logic [CW-1:0] c, input string tag);
    logic [7:0] exp_bits;
    int err, stb;
    exp_bits = 8'b1010_0101;
    cpb = c;
    msb = 1'b1;
    send_word(8'hA5, 1'b1);
    total_cnt++;
    if (valid_o !== 1'b0) $display("FAIL %s_idle_latency: valid_o=%b required 0", tag, valid_o);
    else pass_cnt++;
    capture(0, 10);
    err = 0;
    stb = 0;
    for (int i = 0; i < 10; i++) begin
      if (cap_v[i] !== (i < 8)) err++;
      if (cap_d[i] !== ((i < 8) ? exp_bits[7-i] : 1'b0)) err++;
      if (cap_f[i] !== (i == 7)) err++;
      if (cap_u[i] !== 1'b0) err++;
      if (cap_s[i] === 1'b1) stb++;
    end
    total_cnt++;
    if (cap_v[0] !== 1'b1 || cap_s[0] !== 1'b1)
      $display("FAIL %s_first_bit: valid=%b stb=%b required 1 1", tag, cap_v[0], cap_s[0]);
    else pass_cnt++;
    total_cnt++;
    if (err !== 0) $display("FAIL %s_stream: %0d wrong samples, required 0", tag, err);
    else pass_cnt++;
    total_cnt++;
    if (stb !== 8) $display("FAIL %s_stb_count: got %0d required 8", tag, stb);
    else pass_cnt++;
  endtask

  task automatic test_lsb_cpb3();
    logic [7:0] w;
    int err, nv, stb;
    w = 8'h0F;
    cpb = 8'd3;
    msb = 1'b0;
    send_word(w, 1'b1);
    capture(0, 1);
    cpb = 8'd7;
    msb = 1'b1;
    capture(1, 25);
    err = 0;
    nv = 0;
    stb = 0;
    for (int i = 0; i < 26; i++) begin
      if (cap_v[i] !== (i < 24)) err++;
      if (cap_d[i] !== ((i < 24) ? w[i/3] : 1'b0)) err++;
      if (cap_s[i] !== ((i < 24) && (i % 3 == 0))) err++;
      if (cap_f[i] !== ((i >= 21) && (i < 24))) err++;
      if (cap_v[i] === 1'b1) nv++;
      if (cap_s[i] === 1'b1) stb++;
    end
    total_cnt++;
    if (err !== 0) $display("FAIL lsb_cpb3_stream: %0d wrong samples, required 0", err);
    else pass_cnt++;
    total_cnt++;
    if (nv !== 24) $display("FAIL lsb_cpb3_valid_count: got %0d required 24", nv);
    else pass_cnt++;
    total_cnt++;
    if (stb !== 8) $display("FAIL lsb_cpb3_stb_count: got %0d required 8", stb);
    else pass_cnt++;
    cpb = 8'd1;
  endtask

  task automatic test_back_to_back();
    int err, und, stb;
    cpb = 8'd2;
    msb = 1'b1;
    send_word(8'hFF, 1'b0);
    data_i  = 8'h00;
    last_i  = 1'b1;
    valid_i = 1'b1;
    capture(0, 36);
    err = 0;
    und = 0;
    stb = 0;
    for (int i = 0; i < 36; i++) begin
      if (cap_v[i] !== (i < 32)) err++;
      if (cap_d[i] !== (i < 16)) err++;
      if (cap_f[i] !== ((i == 30) || (i == 31))) err++;
      if (cap_u[i] === 1'b1) und++;
      if (cap_s[i] === 1'b1) stb++;
    end
    total_cnt++;
    if (err !== 0) $display("FAIL b2b_stream: %0d wrong samples, required 0", err);
    else pass_cnt++;
    total_cnt++;
    if (und !== 0) $display("FAIL b2b_underrun: got %0d pulses required 0", und);
    else pass_cnt++;
    total_cnt++;
    if (stb !== 16) $display("FAIL b2b_stb_count: got %0d required 16", stb);
    else pass_cnt++;
    cpb = 8'd1;
  endtask

  task automatic test_underrun();
    logic [7:0] w;
    int err, und, fe;
    w = 8'h3C;
    cpb = 8'd1;
    msb = 1'b1;
    send_word(w, 1'b0);
    capture(0, 12);
    err = 0;
    und = 0;
    fe = 0;
    for (int i = 0; i < 12; i++) begin
      if (cap_v[i] !== (i < 8)) err++;
      if (cap_d[i] !== ((i < 8) ? w[7-i] : 1'b0)) err++;
      if (cap_u[i] === 1'b1) und++;
      if (cap_f[i] === 1'b1) fe++;
    end
    total_cnt++;
    if (err !== 0) $display("FAIL underrun_stream: %0d wrong samples, required 0", err);
    else pass_cnt++;
    total_cnt++;
    if (und !== 1 || cap_u[8] !== 1'b1)
      $display("FAIL underrun_pulse: count %0d at8=%b required 1 1", und, cap_u[8]);
    else pass_cnt++;
    total_cnt++;
    if (fe !== 0) $display("FAIL underrun_frame_end: got %0d required 0", fe);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] w;
    int err, nv;
    cpb = 8'd1;
    msb = 1'b1;
    send_word(8'hA5, 1'b1);
    capture(0, 5);
    total_cnt++;
    if (cap_v[4] !== 1'b1) $display("FAIL rst_mid_active: valid_o=%b required 1", cap_v[4]);
    else pass_cnt++;
    rst_ni = 1'b0;
    #1;
    total_cnt++;
    if ({ready_o, data_o, valid_o, bit_stb_o, frame_end_o, underrun_o} !== 6'b000000)
      $display("FAIL rst_mid_outputs: got %b required 000000",
               {ready_o, data_o, valid_o, bit_stb_o, frame_end_o, underrun_o});
    else pass_cnt++;
    @(posedge clk); #1;
    rst_ni = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if (ready_o !== 1'b1) $display("FAIL rst_mid_ready: got %b required 1", ready_o);
    else pass_cnt++;
    capture(0, 3);
    nv = 0;
    for (int i = 0; i < 3; i++) if (cap_v[i] === 1'b1) nv++;
    total_cnt++;
    if (nv !== 0) $display("FAIL rst_mid_no_partial: got %0d valid cycles required 0", nv);
    else pass_cnt++;
    w = 8'h5A;
    msb = 1'b0;
    send_word(w, 1'b1);
    capture(0, 10);
    err = 0;
    for (int i = 0; i < 10; i++) begin
      if (cap_v[i] !== (i < 8)) err++;
      if (cap_d[i] !== ((i < 8) ? w[i] : 1'b0)) err++;
      if (cap_f[i] !== (i == 7)) err++;
    end
    total_cnt++;
    if (err !== 0) $display("FAIL rst_mid_next_word: %0d wrong samples, required 0", err);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_msb_single(8'd1, "msb_cpb1");
    test_lsb_cpb3();
    test_back_to_back();
    test_underrun();
    test_reset_mid_word();
    test_msb_single(8'd0, "cpb0");
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
